// File: rtl/alu_pkg.sv
// Shared definitions for the ALU pipeline and its result collector:
// flag bit positions inside the 4-bit flag word and small helpers.
package alu_pkg;

  localparam int FLAG_C   = 0;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_BOR = 2;
  localparam int FLAG_INV = 3;
  localparam int FLAG_W   = 4;

  localparam int STAT_W = 16;

  typedef logic [FLAG_W-1:0] alu_flags_t;

  function automatic alu_flags_t packFlags(input logic cOut,
                                           input logic overflow,
                                           input logic borrow,
                                           input logic invalidOp);
    alu_flags_t f;
    f           = '0;
    f[FLAG_C]   = cOut;
    f[FLAG_OVF] = overflow;
    f[FLAG_BOR] = borrow;
    f[FLAG_INV] = invalidOp;
    return f;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_collect_fifo.sv
// Show-ahead FIFO holding packed {seq, flags, y} result entries.
// head_o always shows the oldest entry; a push into a full FIFO is only accepted alongside a pop.
module alu_collect_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic                     pushed_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DATA_W-1:0]        head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] memQ [DEPTH];
  logic [AW-1:0]     wrPtrQ, wrPtrD;
  logic [AW-1:0]     rdPtrQ, rdPtrD;
  logic [CW-1:0]     countQ, countD;
  logic              popEn;
  logic              pushEn;

  assign popEn  = pop_i & (countQ != '0);
  assign pushEn = push_i & ((countQ != FULL_CNT) | popEn);

  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (pushEn) begin
      wrPtrD = wrPtrQ + 1'b1;
    end
    if (popEn) begin
      rdPtrD = rdPtrQ + 1'b1;
    end
    case ({pushEn, popEn})
      2'b10:   countD = countQ + 1'b1;
      2'b01:   countD = countQ - 1'b1;
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
    end
  end

  // Storage needs no reset: nothing is visible until the count says an entry exists.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      memQ[wrPtrQ] <= data_i;
    end
  end

  assign pushed_o = pushEn;
  assign empty_o  = (countQ == '0);
  assign count_o  = countQ;
  assign head_o   = memQ[rdPtrQ];

endmodule

// File: rtl/alu_result_collector.sv
// Receiving end of the 3-stage ALU pipe: buffers results, hands out issue credits, tags sequence numbers.
// Define ALU_COLLECT_STATS_EN to add the stat_results / stat_invalid saturating counters.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  output logic                   issue_ok,
  input  logic                   res_valid,
  input  logic [WIDTH-1:0]       res_y,
  input  logic                   res_c_out,
  input  logic                   res_overflow,
  input  logic                   res_borrow,
  input  logic                   res_invalid_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_y,
  output logic [FLAG_W-1:0]      out_flags,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err_overrun,
  output logic                   err_orphan
`ifdef ALU_COLLECT_STATS_EN
  ,
  output logic [STAT_W-1:0]      stat_results,
  output logic [STAT_W-1:0]      stat_invalid
`endif
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = SEQ_W + FLAG_W + WIDTH;
  localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(DEPTH);

  logic [CW-1:0]      inflightQ, inflightD;
  logic [SEQ_W-1:0]   seqQ, seqD;
  logic               errOverrunQ, errOverrunD;
  logic               errOrphanQ, errOrphanD;
  logic [CW-1:0]      fifoCount;
  logic               fifoEmpty;
  logic               pushed;
  logic               launch;
  logic               retire;
  logic [CW:0]        creditSum;
  logic [ENTRY_W-1:0] pushData;
  logic [ENTRY_W-1:0] headData;

  // Credits come from registered state only, so the issuer sees no combinational path from our inputs.
  assign creditSum = {1'b0, fifoCount} + {1'b0, inflightQ};
  assign issue_ok  = (creditSum < DEPTH_EXT);
  assign launch    = issue_valid & issue_ok;
  assign retire    = res_valid & (inflightQ != '0);
  assign pushData  = {seqQ, packFlags(res_c_out, res_overflow, res_borrow, res_invalid_op), res_y};

  alu_collect_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (retire),
    .data_i   (pushData),
    .pop_i    (out_ready),
    .pushed_o (pushed),
    .empty_o  (fifoEmpty),
    .count_o  (fifoCount),
    .head_o   (headData)
  );

  always_comb begin
    inflightD   = inflightQ;
    seqD        = seqQ;
    errOverrunD = errOverrunQ | (issue_valid & ~issue_ok);
    errOrphanD  = errOrphanQ | (res_valid & (inflightQ == '0)) | (retire & ~pushed);
    case ({launch, retire})
      2'b10:   inflightD = inflightQ + 1'b1;
      2'b01:   inflightD = inflightQ - 1'b1;
      default: inflightD = inflightQ;
    endcase
    if (pushed) begin
      seqD = seqQ + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflightQ   <= '0;
      seqQ        <= '0;
      errOverrunQ <= 1'b0;
      errOrphanQ  <= 1'b0;
    end else begin
      inflightQ   <= inflightD;
      seqQ        <= seqD;
      errOverrunQ <= errOverrunD;
      errOrphanQ  <= errOrphanD;
    end
  end

  // Head is masked while empty so downstream never sees stale storage contents.
  assign out_valid = ~fifoEmpty;
  assign {out_seq, out_flags, out_y} = out_valid ? headData : '0;
  assign occupancy   = fifoCount;
  assign err_overrun = errOverrunQ;
  assign err_orphan  = errOrphanQ;

`ifdef ALU_COLLECT_STATS_EN
  logic [STAT_W-1:0] statResultsQ, statResultsD;
  logic [STAT_W-1:0] statInvalidQ, statInvalidD;

  always_comb begin
    statResultsD = statResultsQ;
    statInvalidD = statInvalidQ;
    if (pushed) begin
      statResultsD = satInc(statResultsQ);
      if (res_invalid_op) begin
        statInvalidD = satInc(statInvalidQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statResultsQ <= '0;
      statInvalidQ <= '0;
    end else begin
      statResultsQ <= statResultsD;
      statInvalidQ <= statInvalidD;
    end
  end

  assign stat_results = statResultsQ;
  assign stat_invalid = statInvalidQ;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: directed scenarios followed by a random phase,
// compared each cycle against a queue-based reference model of the collector.
module tb_alu_result_collector;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SEQ_W = 8;

  typedef struct {
    int         seq;
    logic [3:0] flags;
    logic [7:0] y;
  } result_t;

  logic                   clk;
  logic                   rst_n;
  logic                   issue_valid;
  logic                   issue_ok;
  logic                   res_valid;
  logic [WIDTH-1:0]       res_y;
  logic                   res_c_out;
  logic                   res_overflow;
  logic                   res_borrow;
  logic                   res_invalid_op;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_y;
  logic [3:0]             out_flags;
  logic [SEQ_W-1:0]       out_seq;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   err_overrun;
  logic                   err_orphan;
`ifdef ALU_COLLECT_STATS_EN
  logic [15:0]            stat_results;
  logic [15:0]            stat_invalid;
`endif

  alu_result_collector #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_ok       (issue_ok),
    .res_valid      (res_valid),
    .res_y          (res_y),
    .res_c_out      (res_c_out),
    .res_overflow   (res_overflow),
    .res_borrow     (res_borrow),
    .res_invalid_op (res_invalid_op),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_y          (out_y),
    .out_flags      (out_flags),
    .out_seq        (out_seq),
    .occupancy      (occupancy),
    .err_overrun    (err_overrun),
    .err_orphan     (err_orphan)
`ifdef ALU_COLLECT_STATS_EN
    ,
    .stat_results   (stat_results),
    .stat_invalid   (stat_invalid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: the FIFO as a queue, ops in flight, next seq, sticky errors, stats.
  result_t mQ[$];
  int      mInflight;
  int      mSeq;
  bit      mErrOver;
  bit      mErrOrph;
  int      mStatRes;
  int      mStatInv;
  bit      pipe[3];

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mInflight = 0;
    mSeq      = 0;
    mErrOver  = 0;
    mErrOrph  = 0;
    mStatRes  = 0;
    mStatInv  = 0;
    pipe[0]   = 0;
    pipe[1]   = 0;
    pipe[2]   = 0;
  endtask

  task automatic checkOutput();
    bit      expValid;
    result_t head;
    expValid = (mQ.size() != 0);
    if (expValid) head = mQ[0];
    else begin
      head.seq   = 0;
      head.flags = 4'h0;
      head.y     = 8'h00;
    end
    chk("issue_ok", 32'(issue_ok), 32'((mQ.size() + mInflight) < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(expValid));
    chk("occupancy", 32'(occupancy), 32'(mQ.size()));
    chk("out_y", 32'(out_y), 32'(head.y));
    chk("out_flags", 32'(out_flags), 32'(head.flags));
    chk("out_seq", 32'(out_seq), 32'(head.seq));
    chk("err_overrun", 32'(err_overrun), 32'(mErrOver));
    chk("err_orphan", 32'(err_orphan), 32'(mErrOrph));
`ifdef ALU_COLLECT_STATS_EN
    chk("stat_results", 32'(stat_results), 32'(mStatRes));
    chk("stat_invalid", 32'(stat_invalid), 32'(mStatInv));
`endif
  endtask

  // Drives one cycle of inputs, advances the model by that cycle, then checks at the next negedge.
  // Results normally come back three cycles after launch via the bench's own pipe; forceRes injects extras.
  task automatic applyStimulus(input bit iv, input bit forceRes, input bit ordy,
                               input logic [7:0] y, input logic [3:0] fl);
    bit      rv, credit, launch, retire, pop, accept;
    result_t r;
    rv = pipe[2] | forceRes;
    issue_valid    = iv;
    res_valid      = rv;
    out_ready      = ordy;
    res_y          = y;
    res_c_out      = fl[0];
    res_overflow   = fl[1];
    res_borrow     = fl[2];
    res_invalid_op = fl[3];

    credit = (mQ.size() + mInflight) < DEPTH;
    launch = iv && credit;
    if (iv && !credit) mErrOver = 1;
    retire = rv && (mInflight != 0);
    if (rv && mInflight == 0) mErrOrph = 1;
    pop    = ordy && (mQ.size() != 0);
    accept = retire && ((mQ.size() < DEPTH) || pop);
    if (retire && !accept) mErrOrph = 1;
    if (pop) void'(mQ.pop_front());
    if (accept) begin
      r.seq = mSeq; r.flags = fl; r.y = y;
      mQ.push_back(r);
      mSeq = (mSeq + 1) % (1 << SEQ_W);
      if (mStatRes < 65535) mStatRes++;
      if (fl[3] && mStatInv < 65535) mStatInv++;
    end
    mInflight = mInflight + (launch ? 1 : 0) - (retire ? 1 : 0);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = launch;

    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, ordy, 8'($urandom), 4'($urandom));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    issue_valid = 0; res_valid = 0; out_ready = 0; res_y = '0;
    res_c_out = 0; res_overflow = 0; res_borrow = 0; res_invalid_op = 0;
    modelReset();
    #23;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fill to DEPTH with out_ready=0, then drain");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 8'($urandom), 4'($urandom));
    chk("credit_exhausted", 32'(issue_ok), 32'(0));
    idle(4, 0);
    chk("full_occupancy", 32'(occupancy), 32'(DEPTH));
    idle(5, 1);

    $display("[TB] overflow result held stable under backpressure");
    applyStimulus(1, 0, 0, 8'h00, 4'h0);
    idle(2, 0);
    applyStimulus(0, 0, 0, 8'h7F, 4'b0010);
    chk("dir_y", 32'(out_y), 32'h7F);
    chk("dir_flags", 32'(out_flags), 32'b0010);
    idle(5, 0);
    chk("dir_y_held", 32'(out_y), 32'h7F);
    idle(2, 1);

    $display("[TB] continuous issue with out_ready=1");
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 1, 8'($urandom), 4'($urandom));
    idle(4, 1);

    $display("[TB] overrun and orphan");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 8'($urandom), 4'($urandom));
    chk("dir_overrun", 32'(err_overrun), 32'(1));
    idle(4, 0);
    idle(5, 1);
    applyStimulus(0, 1, 0, 8'h55, 4'h0);
    chk("dir_orphan", 32'(err_orphan), 32'(1));
    chk("dir_orphan_occ", 32'(occupancy), 32'(0));

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++) applyStimulus(i < 2 || i == 4 || i == 3, 0, 0, 8'($urandom), 4'($urandom));
    issue_valid = 0; res_valid = 0; out_ready = 0;
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, 1);

    $display("[TB] random phase");
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom % 3) != 0, ($urandom % 60) == 0, ($urandom % 2) == 1,
                    8'($urandom), 4'($urandom));
    end
    idle(6, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
